reg_write_arbiter: RTL and testbench

Two-requester arbiter for the single write port of the 8×8 register file. It accepts writeback requests from the ALU path (port A) and the memory-load path (port B) through valid/ready handshakes and buffers one request per port. It issues the writes one at a time, holding each on WRITE/INADDRESS/IN until the register file commits it on a clock edge with busywait low. Arbitration is round-robin, except that an older request to the same register always issues first.

---
 rtl/reg_write_arbiter_if.sv | 36 +++
 rtl/reg_write_arbiter.sv | 137 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle between the writeback requesters and the register file.
// master: requesters and stall source; slave: the arbiter.
interface reg_write_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  busywait;
  logic                  REQ_A;
  logic [ADDR_WIDTH-1:0] ADDR_A;
  logic [DATA_WIDTH-1:0] DATA_A;
  logic                  READY_A;
  logic                  REQ_B;
  logic [ADDR_WIDTH-1:0] ADDR_B;
  logic [DATA_WIDTH-1:0] DATA_B;
  logic                  READY_B;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] INADDRESS;
  logic [DATA_WIDTH-1:0] IN;
  logic [1:0]            PENDING;

  modport master (
    output busywait,
    output REQ_A, ADDR_A, DATA_A,
    output REQ_B, ADDR_B, DATA_B,
    input  READY_A, READY_B,
    input  WRITE, INADDRESS, IN, PENDING
  );

  modport slave (
    input  busywait,
    input  REQ_A, ADDR_A, DATA_A,
    input  REQ_B, ADDR_B, DATA_B,
    output READY_A, READY_B,
    output WRITE, INADDRESS, IN, PENDING
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-port round-robin arbiter for the register file write port.
// Ports: CLOCK, RESET (sync, high), bus (slave: A/B req, write out).
module reg_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic               CLOCK,
  input logic               RESET,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state_q, state_d;

  logic                  full_a_q, full_b_q;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q;
  logic                  age_q, age_d;
  logic                  rr_q;
  logic                  sel_q;
  logic [ADDR_WIDTH-1:0] wa_q;
  logic [DATA_WIDTH-1:0] wd_q;

  logic fill_a, fill_b;
  logic both, same, pick_b;
  logic commit, other_full;
  logic load, load_b;
  logic full_a_n, full_b_n;

  assign fill_a = bus.REQ_A && !full_a_q && !RESET;
  assign fill_b = bus.REQ_B && !full_b_q && !RESET;

  assign both   = full_a_q && full_b_q;
  assign same   = addr_a_q == addr_b_q;
  assign commit = (state_q == ISSUE) && !bus.busywait;

  // age_q=1: B slot was filled before A
  always_comb begin
    pick_b = 1'b0;
    unique case (1'b1)
      (full_b_q && !full_a_q): pick_b = 1'b1;
      (both && same):          pick_b = age_q;
      (both && !same):         pick_b = rr_q;
      default:                 pick_b = 1'b0;
    endcase
  end

  assign other_full = sel_q ? full_a_q : full_b_q;

  // Back-to-back issue always hands over to the other slot
  assign load   = ((state_q == IDLE) && (full_a_q || full_b_q))
               || (commit && other_full);
  assign load_b = (state_q == IDLE) ? pick_b : !sel_q;

  assign full_a_n = fill_a || (full_a_q && !(commit && !sel_q));
  assign full_b_n = fill_b || (full_b_q && !(commit && sel_q));

  always_comb begin
    age_d = age_q;
    if (fill_a && fill_b)
      age_d = 1'b0;
    else if (fill_a)
      age_d = full_b_n;
    else if (fill_b)
      age_d = !full_a_n;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (full_a_q || full_b_q)
          state_d = ISSUE;
      ISSUE:
        if (commit && !other_full)
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.WRITE     = (state_q == ISSUE);
    bus.INADDRESS = wa_q;
    bus.IN        = wd_q;
    bus.PENDING   = {full_b_q, full_a_q};
    bus.READY_A   = !full_a_q && !RESET;
    bus.READY_B   = !full_b_q && !RESET;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      full_a_q <= 1'b0;
      full_b_q <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      age_q    <= 1'b0;
      rr_q     <= 1'b0;
      sel_q    <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      if (fill_a) begin
        full_a_q <= 1'b1;
        addr_a_q <= bus.ADDR_A;
        data_a_q <= bus.DATA_A;
      end else if (commit && !sel_q) begin
        full_a_q <= 1'b0;
      end
      if (fill_b) begin
        full_b_q <= 1'b1;
        addr_b_q <= bus.ADDR_B;
        data_b_q <= bus.DATA_B;
      end else if (commit && sel_q) begin
        full_b_q <= 1'b0;
      end
      age_q <= age_d;
      if (commit)
        rr_q <= !sel_q;
      if (load) begin
        sel_q <= load_b;
        wa_q  <= load_b ? addr_b_q : addr_a_q;
        wd_q  <= load_b ? data_b_q : data_a_q;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter.
// Slot/timestamp model plus directed literal expectations.
module tb_reg_write_arbiter;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;

  reg_write_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  reg_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Register file as written by the DUT and as predicted by the model
  logic [7:0] dreg [8];
  logic [7:0] mreg [8];

  // Model: slots with fill timestamps, issuing port (-1 none)
  bit         mfull  [2];
  logic [2:0] maddr  [2];
  logic [7:0] mdata  [2];
  int         mstamp [2];
  int         mcur = -1;
  int         mrr = 0;
  logic [2:0] mwa = '0;
  logic [7:0] mwd = '0;
  int         cyc = 0;
  bit         started = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      dreg[i] = '0;
      mreg[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      mfull[i] = 0;
      maddr[i] = '0;
      mdata[i] = '0;
      mstamp[i] = 0;
    end
  end

  always @(posedge CLOCK) begin
    if (!RESET && bus.WRITE === 1'b1 && bus.busywait === 1'b0)
      dreg[bus.INADDRESS] = bus.IN;
  end

  always @(posedge CLOCK) begin
    bit fa, fb, cm;
    int oth, pk;
    cyc++;
    if (RESET) begin
      mfull[0] = 0;
      mfull[1] = 0;
      mcur = -1;
      mrr = 0;
      mwa = '0;
      mwd = '0;
      started = 1;
    end else begin
      fa = bus.REQ_A && !mfull[0];
      fb = bus.REQ_B && !mfull[1];
      cm = (mcur >= 0) && !bus.busywait;
      if (cm) begin
        mreg[mwa] = mwd;
        oth = 1 - mcur;
        mrr = oth;
        mfull[mcur] = 0;
        if (mfull[oth]) begin
          mcur = oth;
          mwa = maddr[oth];
          mwd = mdata[oth];
        end else begin
          mcur = -1;
        end
      end else if (mcur < 0 && (mfull[0] || mfull[1])) begin
        if (mfull[0] && mfull[1]) begin
          if (maddr[0] == maddr[1])
            pk = (mstamp[1] < mstamp[0]) ? 1 : 0;
          else
            pk = mrr;
        end else begin
          pk = mfull[1] ? 1 : 0;
        end
        mcur = pk;
        mwa = maddr[pk];
        mwd = mdata[pk];
      end
      if (fa) begin
        mfull[0] = 1;
        maddr[0] = bus.ADDR_A;
        mdata[0] = bus.DATA_A;
        mstamp[0] = cyc;
      end
      if (fb) begin
        mfull[1] = 1;
        maddr[1] = bus.ADDR_B;
        mdata[1] = bus.DATA_B;
        mstamp[1] = cyc;
      end
    end
  end

  always @(negedge CLOCK) begin
    if (started) begin
      chk("m_WRITE", 32'(bus.WRITE), 32'(mcur >= 0));
      chk("m_INADDRESS", 32'(bus.INADDRESS), 32'(mwa));
      chk("m_IN", 32'(bus.IN), 32'(mwd));
      chk("m_PENDING", 32'(bus.PENDING), 32'({mfull[1], mfull[0]}));
      chk("m_READY_A", 32'(bus.READY_A), 32'(!mfull[0] && !RESET));
      chk("m_READY_B", 32'(bus.READY_B), 32'(!mfull[1] && !RESET));
    end
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_a(input logic [2:0] a, input logic [7:0] d);
    bus.REQ_A = 1'b1;
    bus.ADDR_A = a;
    bus.DATA_A = d;
  endtask

  task automatic set_b(input logic [2:0] a, input logic [7:0] d);
    bus.REQ_B = 1'b1;
    bus.ADDR_B = a;
    bus.DATA_B = d;
  endtask

  task automatic clr();
    bus.REQ_A = 1'b0;
    bus.REQ_B = 1'b0;
  endtask

  initial begin
    bus.busywait = 1'b0;
    bus.REQ_A = 1'b0;
    bus.ADDR_A = '0;
    bus.DATA_A = '0;
    bus.REQ_B = 1'b0;
    bus.ADDR_B = '0;
    bus.DATA_B = '0;
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    #1;
    chk("rst_write", 32'(bus.WRITE), 0);
    chk("rst_addr", 32'(bus.INADDRESS), 0);
    chk("rst_in", 32'(bus.IN), 0);
    chk("rst_pend", 32'(bus.PENDING), 0);
    chk("rst_rdy_a", 32'(bus.READY_A), 1);
    chk("rst_rdy_b", 32'(bus.READY_B), 1);

    // Simultaneous, different addresses, pointer at A
    set_a(3'd1, 8'h11);
    set_b(3'd2, 8'h22);
    step();
    clr();
    step();
    chk("sim_w1", 32'(bus.WRITE), 1);
    chk("sim_a1", 32'(bus.INADDRESS), 1);
    chk("sim_d1", 32'(bus.IN), 32'h11);
    step();
    chk("sim_w2", 32'(bus.WRITE), 1);
    chk("sim_a2", 32'(bus.INADDRESS), 2);
    chk("sim_d2", 32'(bus.IN), 32'h22);
    step();
    chk("sim_w3", 32'(bus.WRITE), 0);
    chk("sim_r1", 32'(dreg[1]), 32'h11);
    chk("sim_r2", 32'(dreg[2]), 32'h22);

    // Single write
    set_a(3'd3, 8'h5A);
    step();
    clr();
    step();
    chk("one_w", 32'(bus.WRITE), 1);
    chk("one_a", 32'(bus.INADDRESS), 3);
    chk("one_d", 32'(bus.IN), 32'h5A);
    step();
    chk("one_w0", 32'(bus.WRITE), 0);
    chk("one_r3", 32'(dreg[3]), 32'h5A);

    // Same address: B accepted one edge before A
    set_b(3'd4, 8'hBB);
    step();
    clr();
    set_a(3'd4, 8'hAA);
    step();
    clr();
    chk("same_d1", 32'(bus.IN), 32'hBB);
    step();
    chk("same_d2", 32'(bus.IN), 32'hAA);
    step();
    chk("same_r4", 32'(dreg[4]), 32'hAA);

    // Pointer now at B; same address simultaneous -> A is older
    set_a(3'd0, 8'h0F);
    step();
    clr();
    step();
    step();
    set_a(3'd5, 8'h51);
    set_b(3'd5, 8'h52);
    step();
    clr();
    step();
    chk("age_first", 32'(bus.IN), 32'h51);
    step();
    step();
    chk("age_r5", 32'(dreg[5]), 32'h52);

    // Pointer at B again via one A commit; different addresses -> B
    set_a(3'd0, 8'h0E);
    step();
    clr();
    step();
    step();
    set_a(3'd1, 8'h31);
    set_b(3'd2, 8'h32);
    step();
    clr();
    step();
    chk("rr_b_first", 32'(bus.INADDRESS), 2);
    step();
    step();

    // Stall on a B write
    set_b(3'd6, 8'h66);
    step();
    clr();
    bus.busywait = 1'b1;
    step();
    chk("stall_w0", 32'(bus.WRITE), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_w", 32'(bus.WRITE), 1);
      chk("stall_a", 32'(bus.INADDRESS), 6);
      chk("stall_d", 32'(bus.IN), 32'h66);
      chk("stall_rdy", 32'(bus.READY_B), 0);
    end
    bus.busywait = 1'b0;
    step();
    chk("stall_end", 32'(bus.WRITE), 0);
    chk("stall_rdyb", 32'(bus.READY_B), 1);
    chk("stall_r6", 32'(dreg[6]), 32'h66);

    // Back-pressure on A while stalled
    bus.busywait = 1'b1;
    set_a(3'd7, 8'hC0);
    step();
    bus.DATA_A = 8'hC1;
    step();
    step();
    chk("bp_rdy0", 32'(bus.READY_A), 0);
    chk("bp_pend", 32'(bus.PENDING), 1);
    bus.busywait = 1'b0;
    step();
    chk("bp_rdy1", 32'(bus.READY_A), 1);
    chk("bp_r7a", 32'(dreg[7]), 32'hC0);
    step();
    clr();
    chk("bp_pend2", 32'(bus.PENDING), 1);
    step();
    chk("bp_d2", 32'(bus.IN), 32'hC1);
    step();
    chk("bp_r7b", 32'(dreg[7]), 32'hC1);

    // Reset during issue with both slots full
    bus.busywait = 1'b1;
    set_a(3'd2, 8'hE1);
    set_b(3'd3, 8'hE2);
    step();
    clr();
    step();
    chk("rmi_w", 32'(bus.WRITE), 1);
    chk("rmi_p", 32'(bus.PENDING), 3);
    RESET = 1'b1;
    step();
    chk("rmi_w0", 32'(bus.WRITE), 0);
    chk("rmi_p0", 32'(bus.PENDING), 0);
    chk("rmi_rdy", 32'(bus.READY_A), 0);
    RESET = 1'b0;
    bus.busywait = 1'b0;
    step();
    step();
    chk("rmi_r2", 32'(dreg[2]), 32'h32);
    chk("rmi_r3", 32'(dreg[3]), 32'h5A);

    // Mixed traffic pattern, checked cycle by cycle against the model
    for (int i = 0; i < 40; i++) begin
      bus.REQ_A = (i % 3) != 0;
      bus.ADDR_A = 3'(i % 8);
      bus.DATA_A = 8'(i * 7);
      bus.REQ_B = (i % 4) < 2;
      bus.ADDR_B = 3'((i * 3) % 8);
      bus.DATA_B = 8'(i * 13 + 1);
      bus.busywait = (i % 5) == 2;
      step();
    end
    clr();
    bus.busywait = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 8; i++)
      chk("regfile", 32'(dreg[i]), 32'(mreg[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
